// File: rtl/photo_frame_pkg.sv
// Shared types and constants for the photo frame index controller.
// Used by key_debounce and photo_idx_ctrl.
package photo_frame_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

  localparam logic KEY_PRESSED = 1'b0;
  localparam int   DISP_W      = 8;

  function automatic int ms2cyc(
    input int clk_hz,
    input int ms
  );
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// 2-FF synchroniser, stability counter and press pulse for one
// active-low push-button.
module key_debounce
  import photo_frame_pkg::*;
#(
  parameter int DEB_CYC = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic press_o
);

  localparam int CW = (DEB_CYC > 1) ?
                      $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(DEB_CYC - 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == LAST) begin
        level_d = sync_q[1];
        press_d = (sync_q[1] == KEY_PRESSED);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= {2{~KEY_PRESSED}};
      level_q <= ~KEY_PRESSED;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/photo_idx_ctrl.sv
// Photo index controller: debounced next/prev/auto keys and slideshow.
// Define PHOTO_IDX_BCD_OUT_EN for BCD o_data instead of binary.
module photo_idx_ctrl
  import photo_frame_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int SLIDE_MS    = 3000,
  parameter int NUM_PHOTOS  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_key_next,
  input  logic              i_key_prev,
  input  logic              i_key_auto,
  output logic [DISP_W-1:0] o_data,
  output logic              o_upd,
  output logic              o_auto
);

  localparam int DEB_CYC   = ms2cyc(CLK_HZ, DEBOUNCE_MS);
  localparam int SLIDE_CYC = ms2cyc(CLK_HZ, SLIDE_MS);
  localparam int IDX_W     = $clog2(NUM_PHOTOS);
  localparam int SW        = (SLIDE_CYC > 1) ?
                             $clog2(SLIDE_CYC) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_PHOTOS - 1);
  localparam logic [SW-1:0] SLIDE_LAST =
    SW'(SLIDE_CYC - 1);

  function automatic logic [DISP_W-1:0] to_disp(
    input logic [IDX_W-1:0] idx
  );
`ifdef PHOTO_IDX_BCD_OUT_EN
    int v;
    v = int'(idx);
    return {4'(v / 10), 4'(v % 10)};
`else
    return DISP_W'(idx);
`endif
  endfunction

  logic next_ev, prev_ev, auto_ev;

  key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_next (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .key_i   (i_key_next),
    .press_o (next_ev)
  );

  key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_prev (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .key_i   (i_key_prev),
    .press_o (prev_ev)
  );

  key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_auto (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .key_i   (i_key_auto),
    .press_o (auto_ev)
  );

  mode_e             mode_q, mode_d;
  logic [SW-1:0]     slide_q, slide_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DISP_W-1:0] data_q, data_d;
  logic              upd_q, upd_d;
  logic              tick;
  logic              manual;

  always_comb begin
    mode_d  = mode_q;
    slide_d = slide_q;
    idx_d   = idx_q;
    upd_d   = 1'b0;
    tick    = 1'b0;
    manual  = next_ev | prev_ev;

    // a manual step restarts the dwell and swallows a coincident tick
    if (mode_q == MODE_AUTO) begin
      if (manual) begin
        slide_d = '0;
      end else if (slide_q == SLIDE_LAST) begin
        slide_d = '0;
        tick    = ~auto_ev;
      end else begin
        slide_d = slide_q + SW'(1);
      end
    end

    if (auto_ev) begin
      mode_d  = (mode_q == MODE_AUTO) ?
                MODE_MANUAL : MODE_AUTO;
      slide_d = '0;
    end

    unique case (1'b1)
      next_ev & ~prev_ev,
      tick: begin
        idx_d = (idx_q == LAST_IDX) ?
                '0 : idx_q + IDX_W'(1);
        upd_d = 1'b1;
      end
      prev_ev & ~next_ev: begin
        idx_d = (idx_q == '0) ?
                LAST_IDX : idx_q - IDX_W'(1);
        upd_d = 1'b1;
      end
      default: ;
    endcase

    data_d = to_disp(idx_d);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q  <= MODE_MANUAL;
      slide_q <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      upd_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      slide_q <= slide_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      upd_q   <= upd_d;
    end
  end

  assign o_data = data_q;
  assign o_upd  = upd_q;
  assign o_auto = (mode_q == MODE_AUTO);

endmodule

// File: tb/tb_photo_idx_ctrl.sv
// Directed bench for photo_idx_ctrl at 1 ms per cycle.
// Honours PHOTO_IDX_BCD_OUT_EN for expected display values.
module tb_photo_idx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_next = 1'b1;
  logic       key_prev = 1'b1;
  logic       key_auto = 1'b1;
  logic [7:0] o_data;
  logic       o_upd;
  logic       o_auto;

  int n_chk  = 0;
  int n_fail = 0;

  photo_idx_ctrl #(
    .CLK_HZ      (1000),
    .DEBOUNCE_MS (4),
    .SLIDE_MS    (10),
    .NUM_PHOTOS  (12)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_key_next (key_next),
    .i_key_prev (key_prev),
    .i_key_auto (key_auto),
    .o_data     (o_data),
    .o_upd      (o_upd),
    .o_auto     (o_auto)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] disp(input int i);
`ifdef PHOTO_IDX_BCD_OUT_EN
    return {4'(i / 10), 4'(i % 10)};
`else
    return 8'(i);
`endif
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_upd(
    input  int max,
    output int n,
    output bit seen
  );
    n    = 0;
    seen = 1'b0;
    while (!seen && n < max) begin
      step();
      n++;
      if (o_upd) seen = 1'b1;
    end
  endtask

  task automatic count_upd(
    input  int cyc,
    output int cnt
  );
    cnt = 0;
    for (int i = 0; i < cyc; i++) begin
      step();
      if (o_upd) cnt++;
    end
  endtask

  task automatic wait_auto(
    input  logic lvl,
    output int   n
  );
    n = 0;
    while (o_auto !== lvl && n < 12) begin
      step();
      n++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // which: 0 = next, 1 = prev
  task automatic press(
    input  int which,
    output bit seen
  );
    int n;
    if (which == 0) key_next = 1'b0;
    else            key_prev = 1'b0;
    wait_upd(12, n, seen);
    key_next = 1'b1;
    key_prev = 1'b1;
    repeat (8) step();
  endtask

  initial begin
    int n, cnt;
    bit seen;

    step();
    step();
    chk("rst_data", o_data, 8'h00);
    chk("rst_upd", o_upd, 1'b0);
    chk("rst_auto", o_auto, 1'b0);
    rst_n = 1'b1;
    step();
    chk("post_rst_data", o_data, 8'h00);

    // bounce then settle low
    key_next = 1'b0;
    step();
    key_next = 1'b1;
    step();
    key_next = 1'b0;
    wait_upd(20, n, seen);
    chk("bounce_seen", seen, 1'b1);
    chk("bounce_lat", n, 7);
    chk("bounce_data", o_data, disp(1));
    count_upd(15, cnt);
    chk("bounce_norep", cnt, 0);
    key_next = 1'b1;
    count_upd(10, cnt);
    chk("release_noev", cnt, 0);

    // 3-cycle glitch is rejected
    key_next = 1'b0;
    repeat (3) step();
    key_next = 1'b1;
    count_upd(20, cnt);
    chk("glitch_upd", cnt, 0);
    chk("glitch_data", o_data, disp(1));

    // wrap both directions
    do_reset();
    for (int k = 1; k <= 11; k++) begin
      press(0, seen);
      chk("wrap_up", o_data, disp(k));
    end
    press(0, seen);
    chk("wrap_hi_upd", seen, 1'b1);
    chk("wrap_hi", o_data, disp(0));
    press(1, seen);
    chk("wrap_lo_upd", seen, 1'b1);
    chk("wrap_lo", o_data, disp(11));

    // slideshow
    do_reset();
    key_auto = 1'b0;
    wait_auto(1'b1, n);
    chk("auto_on", o_auto, 1'b1);
    chk("auto_data0", o_data, disp(0));
    key_auto = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      wait_upd(20, n, seen);
      chk("slide_period", n, 10);
      chk("slide_data", o_data, disp(k));
    end

    // next lands exactly on the tick cycle
    repeat (3) step();
    key_next = 1'b0;
    wait_upd(20, n, seen);
    chk("coll_lat", n, 7);
    chk("coll_data", o_data, disp(4));
    key_next = 1'b1;
    wait_upd(20, n, seen);
    chk("coll_next_tick", n, 10);
    chk("coll_tick_data", o_data, disp(5));

    // async reset mid-slide with next held
    key_next = 1'b0;
    repeat (2) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_data", o_data, 8'h00);
    chk("arst_auto", o_auto, 1'b0);
    chk("arst_upd", o_upd, 1'b0);
    step();
    rst_n = 1'b1;
    wait_upd(12, n, seen);
    chk("rst_held_lat", n, 7);
    chk("rst_held_data", o_data, disp(1));
    count_upd(30, cnt);
    chk("rst_held_once", cnt, 0);
    key_next = 1'b1;
    repeat (10) step();

    // leave slideshow right after a tick
    key_auto = 1'b0;
    wait_auto(1'b1, n);
    chk("auto_on2", o_auto, 1'b1);
    key_auto = 1'b1;
    wait_upd(20, n, seen);
    chk("auto2_tick", n, 10);
    chk("auto2_data", o_data, disp(2));
    key_auto = 1'b0;
    wait_auto(1'b0, n);
    chk("auto_off_lat", n, 7);
    chk("auto_off", o_auto, 1'b0);
    key_auto = 1'b1;
    count_upd(50, cnt);
    chk("frozen_upd", cnt, 0);
    chk("frozen_data", o_data, disp(2));

    // next and prev together cancel
    key_next = 1'b0;
    key_prev = 1'b0;
    count_upd(20, cnt);
    chk("np_upd", cnt, 0);
    chk("np_data", o_data, disp(2));
    key_next = 1'b1;
    key_prev = 1'b1;
    repeat (10) step();

    // long hold gives a single step
    key_prev = 1'b0;
    count_upd(100, cnt);
    chk("hold_cnt", cnt, 1);
    chk("hold_data", o_data, disp(1));
    key_prev = 1'b1;
    repeat (10) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
